// File: rtl/idct2_pkg.sv
// idct2_pkg: shared types, widths and the VVC 32x32 DCT-II matrix for the
// sequential 1-D inverse DCT.
//   DCT_MAT[k][j] : basis row k (frequency), column j (spatial position).
//   size_e        : transform size code as carried on the N input.
//   vec_t         : 32 x 16-bit elements, element 0 in the MSBs of the
//                   flat 512-bit bus.
package idct2_pkg;

   localparam int COEF_W = 16;
   localparam int ACC_W  = 30;
   localparam int MAT_W  = 8;

   typedef enum logic [1:0] {SZ4 = 2'b00, SZ8 = 2'b01, SZ16 = 2'b10, SZ32 = 2'b11} size_e;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COMPUTE = 2'd1, ST_DONE = 2'd2} state_e;

   typedef logic [0:31][COEF_W-1:0]      vec_t;
   typedef logic [31:0][31:0][MAT_W-1:0] mat_t;

   function automatic logic [5:0] size_of(input size_e sz);
      case (sz)
         SZ4:     return 6'd4;
         SZ8:     return 6'd8;
         SZ16:    return 6'd16;
         default: return 6'd32;
      endcase
   endfunction

   // Magnitude of 64*sqrt(2)*cos(m*pi/64) as used by the VVC integer transform.
   function automatic int cos_mag(input int m);
      case (m)
         0:  return 64;  1:  return 90;  2:  return 90;  3:  return 90;
         4:  return 89;  5:  return 88;  6:  return 87;  7:  return 85;
         8:  return 83;  9:  return 82;  10: return 80;  11: return 78;
         12: return 75;  13: return 73;  14: return 70;  15: return 67;
         16: return 64;  17: return 61;  18: return 57;  19: return 54;
         20: return 50;  21: return 46;  22: return 43;  23: return 38;
         24: return 36;  25: return 31;  26: return 25;  27: return 22;
         28: return 18;  29: return 13;  30: return 9;   31: return 4;
         default: return 0;
      endcase
   endfunction

   // Entry [r][c] is the cosine of angle r*(2c+1)*pi/64 folded into the first
   // quadrant; the quadrant gives the sign. r*(2c+1) is never an odd multiple
   // of 32 for r<32, so the zero crossings never land on an entry.
   function automatic mat_t build_mat();
      mat_t m;
      int   a;
      int   v;
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 32; c++) begin
            a = (r * (2 * c + 1)) % 128;
            if (a < 32)      v =  cos_mag(a);
            else if (a < 64) v = -cos_mag(64 - a);
            else if (a < 96) v = -cos_mag(a - 64);
            else             v =  cos_mag(128 - a);
            m[r][c] = MAT_W'(v);
         end
      end
      return m;
   endfunction

   localparam mat_t DCT_MAT = build_mat();

endpackage

// File: rtl/idct2_1d_seq_dot32.sv
// idct2_dot32: combinational 32-term dot product of a coefficient vector with
// one column of the DCT matrix, rows picked with stride 32/S.
//   coef_i : 32 signed coefficients (element 0 = DC)
//   col_i  : output column j
//   size_i : transform size; coefficients k >= S contribute nothing
//   sum_o  : signed ACC_W-bit sum of X[k]*M[k*(32/S)][j] for k < S
module idct2_dot32 import idct2_pkg::*; (
   input  vec_t                     coef_i,
   input  logic [4:0]               col_i,
   input  size_e                    size_i,
   output logic signed [ACC_W-1:0]  sum_o
);

   logic [2:0] stride_sh;   // log2(32/S)

   always_comb begin
      case (size_i)
         SZ4:     stride_sh = 3'd3;
         SZ8:     stride_sh = 3'd2;
         SZ16:    stride_sh = 3'd1;
         default: stride_sh = 3'd0;
      endcase
   end

   always_comb begin
      sum_o = '0;
      for (int k = 0; k < 32; k++) begin
         if (k < int'(size_of(size_i))) begin
            // 16x8 product fits 24 bits; the 32-term sum fits ACC_W.
            sum_o = sum_o + ACC_W'(signed'(coef_i[k]))
                          * ACC_W'(signed'(DCT_MAT[5'(k << stride_sh)][col_i]));
         end
      end
   end

endmodule

// File: rtl/idct2_1d_seq.sv
// idct2_1d_seq: sequential 1-D inverse DCT-II (VVC sizes 4/8/16/32), one
// output sample per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   N, X_in, in_valid   : size code and coefficient vector, accepted when
//   in_ready            :   in_valid && in_ready (IDLE only)
//   Y, out_valid        : result vector, held while out_valid
//   out_ready           : downstream accepts Y (DONE only)
//   dbg_state           : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its data until then, and the receiver may ignore valid while
// its ready is low.
// Optional build macro IDCT_ZERO_SKIP_EN: an accepted vector whose S used
// coefficients are all zero goes straight to DONE with Y = 0.
module idct2_1d_seq import idct2_pkg::*; #(
   parameter int SHIFT = 7,
   parameter int OUT_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    N,
   input  logic [511:0]  X_in,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [511:0]  Y,
   output logic          out_valid,
   input  logic          out_ready,
   output state_e        dbg_state
);

   localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (SHIFT - 1));
   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

   state_e                   state_q, state_d;
   vec_t                     x_q, y_q;
   size_e                    size_q;
   logic [4:0]               j_q;
   logic                     load, step;
   logic signed [ACC_W-1:0]  dot_sum, rnd_sum, shifted;
   logic [COEF_W-1:0]        y_sat;

   idct2_dot32 u_dot (
      .coef_i (x_q),
      .col_i  (j_q),
      .size_i (size_q),
      .sum_o  (dot_sum)
   );

`ifdef IDCT_ZERO_SKIP_EN
   vec_t x_in_v;
   logic in_zero;
   assign x_in_v = X_in;
   always_comb begin
      in_zero = 1'b1;
      for (int k = 0; k < 32; k++) begin
         if (k < int'(size_of(size_e'(N))) && x_in_v[k] != '0) in_zero = 1'b0;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      step      = 1'b0;
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               state_d = ST_COMPUTE;
`ifdef IDCT_ZERO_SKIP_EN
               if (in_zero) state_d = ST_DONE;
`endif
            end
         end
         ST_COMPUTE: begin
            step = 1'b1;
            if (j_q == 5'(size_of(size_q) - 6'd1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Round, floor-shift, then clip to the signed OUT_W range.
   always_comb begin
      rnd_sum = dot_sum + RND;
      shifted = rnd_sum >>> SHIFT;
      if (shifted > OUT_MAX)      y_sat = COEF_W'(OUT_MAX);
      else if (shifted < OUT_MIN) y_sat = COEF_W'(OUT_MIN);
      else                        y_sat = COEF_W'(shifted);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         size_q <= SZ4;
         j_q    <= '0;
         y_q    <= '0;
      end else if (load) begin
         x_q    <= X_in;
         size_q <= size_e'(N);
         j_q    <= '0;
         y_q    <= '0;
      end else if (step) begin
         y_q[j_q] <= y_sat;
         j_q      <= j_q + 5'd1;
      end
   end

   assign Y         = y_q;
   assign dbg_state = state_q;

endmodule
